// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// The len clamp lives here so other sources of the pattern can reuse it.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   localparam int PAT_W_DEF = 8;
   localparam int LEN_W_DEF = 4;
   localparam int REP_W_DEF = 4;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter: sends the low len bits of a pattern MSB-first,
// repeated reps times back-to-back, with registered outputs throughout.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int REP_W = REP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [REP_W-1:0] reps,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [PAT_W-1:0] pat_r;
   logic [PAT_W-1:0] sh_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] bit_cnt;
   logic [REP_W-1:0] rep_cnt;

   logic [LEN_W-1:0] cap_len;
   logic [PAT_W-1:0] cap_pat;
   logic [REP_W-1:0] cap_reps;

   // The pattern is stored left-aligned so the next bit to send is always the MSB.
   always_comb begin
      cap_len  = LEN_W'(clamp_len(32'(len), PAT_W));
      cap_pat  = pattern << (PAT_W - 32'(cap_len));
      cap_reps = (reps == '0) ? '0 : reps - REP_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pat_r      <= '0;
         sh_r       <= '0;
         len_r      <= '0;
         bit_cnt    <= '0;
         rep_cnt    <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  pat_r   <= cap_pat;
                  len_r   <= cap_len;
                  rep_cnt <= cap_reps;
                  if (cap_len == '0) begin
                     state   <= DONE;
                     bit_cnt <= '0;
                     done    <= 1'b1;
                  end else begin
                     state      <= SEND;
                     bit_cnt    <= cap_len - LEN_W'(1);
                     sh_r       <= cap_pat << 1;
                     dout       <= cap_pat[PAT_W-1];
                     dout_valid <= 1'b1;
                     busy       <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end

            SEND: begin
               if (abort) begin
                  state      <= IDLE;
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
               end else if (bit_cnt == '0) begin
                  if (rep_cnt == '0) begin
                     state      <= DONE;
                     dout       <= 1'b0;
                     dout_valid <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     // Repetition boundary: reload straight from the captured copy, no gap.
                     rep_cnt <= rep_cnt - REP_W'(1);
                     bit_cnt <= len_r - LEN_W'(1);
                     dout    <= pat_r[PAT_W-1];
                     sh_r    <= pat_r << 1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - LEN_W'(1);
                  dout    <= sh_r[PAT_W-1];
                  sh_r    <= sh_r << 1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: expected serial streams come from a queue built directly
// from pattern/len/reps, compared cycle by cycle against the DUT outputs.
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] reps;
   logic       dout;
   logic       dout_valid;
   logic       busy;
   logic       done;

   int pass_cnt  = 0;
   int check_cnt = 0;

   logic [7:0] r_pat;
   logic [3:0] r_len;
   logic [3:0] r_reps;
   int         r_cut;
   bit         r_cut_rst;
   bit         r_scr;

   seq_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pattern   (pattern),
      .len       (len),
      .reps      (reps),
      .abort     (abort),
      .dout      (dout),
      .dout_valid(dout_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Expected value is packed as {dout, dout_valid, busy, done}.
   task automatic checkOutput(input string tag, input logic [3:0] expv);
      logic [3:0] obs;
      obs = {dout, dout_valid, busy, done};
      check_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("[TB] FAIL %s: dout/valid/busy/done observed=%b expected=%b", tag, obs, expv);
   endtask

   task automatic idleCheck(input string tag);
      step;
      checkOutput(tag, 4'b0000);
   endtask

   // Starts one transmission and checks every cycle until done (or until cut short
   // by abort/reset after cut_after bits). Leaves the DUT in its DONE cycle on completion.
   task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp,
                                input int cut_after, input bit cut_is_reset, input bit scramble);
      logic exp_bits[$];
      int   eff_len;
      int   eff_reps;
      eff_len  = (ln > 4'd8) ? 8 : int'(ln);
      eff_reps = (rp == 4'd0) ? 1 : int'(rp);
      for (int r = 0; r < eff_reps; r++)
         for (int i = eff_len - 1; i >= 0; i--)
            exp_bits.push_back(pat[i]);

      pattern = pat;
      len     = ln;
      reps    = rp;
      start   = 1'b1;
      step;
      abort = 1'b0;
      if (!scramble) start = 1'b0;

      for (int k = 0; k < exp_bits.size(); k++) begin
         checkOutput($sformatf("bit%0d", k), {exp_bits[k], 3'b110});
         if (scramble) begin
            start   = 1'($urandom_range(0, 1));
            pattern = 8'($urandom);
            len     = 4'($urandom);
            reps    = 4'($urandom);
         end
         if (k + 1 == cut_after) begin
            start = 1'b0;
            if (cut_is_reset) rst = 1'b1;
            else abort = 1'b1;
            step;
            rst   = 1'b0;
            abort = 1'b0;
            checkOutput(cut_is_reset ? "reset_cut" : "abort_cut", 4'b0000);
            return;
         end
         step;
      end
      start = 1'b0;
      checkOutput("done_pulse", 4'b0001);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b1;
      abort   = 1'b0;
      pattern = 8'hFF;
      len     = 4'd4;
      reps    = 4'd1;
      step;
      step;
      checkOutput("reset_state", 4'b0000);
      rst   = 1'b0;
      start = 1'b0;
      idleCheck("idle_after_reset");

      $display("[TB] single pattern and repetitions");
      applyStimulus(8'h0B, 4'd4, 4'd1, -1, 1'b0, 1'b0);
      idleCheck("done_one_cycle");
      applyStimulus(8'h0B, 4'd4, 4'd3, -1, 1'b0, 1'b0);
      idleCheck("idle_after_reps");

      $display("[TB] boundaries");
      applyStimulus(8'hA5, 4'd0, 4'd2, -1, 1'b0, 1'b0);
      idleCheck("idle_after_len0");
      applyStimulus(8'h96, 4'd15, 4'd1, -1, 1'b0, 1'b0);
      idleCheck("idle_after_len15");
      applyStimulus(8'h0B, 4'd4, 4'd0, -1, 1'b0, 1'b0);
      idleCheck("idle_after_reps0");

      $display("[TB] ignored inputs and back-to-back");
      applyStimulus(8'h0B, 4'd4, 4'd2, -1, 1'b0, 1'b1);
      applyStimulus(8'h0D, 4'd4, 4'd1, -1, 1'b0, 1'b0);
      idleCheck("idle_after_chain");
      abort = 1'b1;
      applyStimulus(8'h35, 4'd6, 4'd1, -1, 1'b0, 1'b0);
      idleCheck("idle_after_start_abort");

      $display("[TB] abort and reset");
      applyStimulus(8'h0B, 4'd4, 4'd1, 2, 1'b0, 1'b0);
      idleCheck("no_done_after_abort");
      applyStimulus(8'h0B, 4'd4, 4'd2, 3, 1'b1, 1'b0);
      idleCheck("no_done_after_reset");
      applyStimulus(8'h06, 4'd3, 4'd1, -1, 1'b0, 1'b0);
      idleCheck("idle_after_fresh");
      abort = 1'b1;
      idleCheck("abort_in_idle");
      abort = 1'b0;

      $display("[TB] randomized transmissions");
      repeat (25) begin
         r_pat     = 8'($urandom);
         r_len     = 4'($urandom_range(0, 15));
         r_reps    = 4'($urandom_range(0, 3));
         r_cut     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1;
         r_cut_rst = 1'($urandom_range(0, 1));
         r_scr     = 1'($urandom_range(0, 1));
         applyStimulus(r_pat, r_len, r_reps, r_cut, r_cut_rst, r_scr);
         if ($urandom_range(0, 1) == 1) idleCheck("rand_idle");
      end
      idleCheck("final_idle");

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
